// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the serial slice adder
package adder_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits consumed per clock by the slice datapath
    localparam int SLICE_W = 2;

endpackage

// File: rtl/serial_slice_adder_if.sv
// rtl/serial_slice_adder_if.sv - operand/result handshake bundle of the serial slice adder
//
// master: operand producer / result consumer (drives in_valid, a, b, c, out_ready)
// slave : the adder (drives in_ready, out_valid, sum, carry, ovf, busy)
interface serial_slice_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, sum, carry, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, sum, carry, ovf, busy
    );
endinterface

// File: rtl/serial_slice_adder_slice.sv
// rtl/serial_slice_adder_slice.sv - 2-bit combinational slice adder (dataflow)
//
// a, b  : 2-bit operand slices
// c     : carry into bit 0
// sum   : 2-bit slice sum
// carry : carry out of bit 1
module twoBitAdder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c,
    output logic [1:0] sum,
    output logic       carry
);
    logic c1;

    assign sum[0] = a[0] ^ b[0] ^ c;
    assign c1     = (a[0] & b[0]) | (c & (a[0] ^ b[0]));
    assign sum[1] = a[1] ^ b[1] ^ c1;
    assign carry  = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
endmodule

// File: rtl/serial_slice_adder.sv
// rtl/serial_slice_adder.sv - multi-cycle WIDTH-bit adder built from one 2-bit slice adder
//
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : slave side of serial_slice_adder_if
//         in_valid/in_ready + a, b, c   operand handshake
//         out_valid/out_ready + sum, carry, ovf   result handshake
//         busy   high while an operation is in RUN or DONE
module serial_slice_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_slice_adder_if.slave   bus
);
    localparam int SLICES = WIDTH / SLICE_W;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("serial_slice_adder: WIDTH must be even and >= 2");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cy_q, cy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_carry;
    logic               last_slice;

    twoBitAdder u_slice (
        .a     (a_sh_q[SLICE_W-1:0]),
        .b     (b_sh_q[SLICE_W-1:0]),
        .c     (cy_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    assign last_slice = (idx_q == IDX_W'(SLICES - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cy_d    = cy_q;
        idx_d   = idx_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    cy_d    = bus.c;
                    idx_d   = '0;
                    acc_d   = '0;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                a_sh_d = a_sh_q >> SLICE_W;
                b_sh_d = b_sh_q >> SLICE_W;
                // Slice sums enter at the top so that after SLICES shifts
                // slice 0 has reached bits [1:0].
                acc_d = acc_q >> SLICE_W;
                acc_d[WIDTH-1 -: SLICE_W] = slice_sum;
                cy_d  = slice_carry;
                idx_d = idx_q + 1'b1;
                if (last_slice) begin
                    sum_d   = acc_d;
                    carry_d = slice_carry;
                    ovf_d   = (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            idx_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            idx_q   <= idx_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_slice_adder.sv
// tb/tb_serial_slice_adder.sv - self-checking bench for serial_slice_adder (WIDTH=8 and WIDTH=2)
module tb_serial_slice_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_slice_adder_if #(.WIDTH(8)) if8 ();
    serial_slice_adder_if #(.WIDTH(2)) if2 ();

    serial_slice_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_slice_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // Directed vectors with hand-computed results
    logic [7:0] vec_a   [5] = '{8'hFF, 8'h7F, 8'h80, 8'h00, 8'h5A};
    logic [7:0] vec_b   [5] = '{8'h01, 8'h01, 8'h80, 8'h00, 8'h3C};
    logic       vec_c   [5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    logic [7:0] vec_sum [5] = '{8'h00, 8'h80, 8'h00, 8'h01, 8'h97};
    logic       vec_cy  [5] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
    logic       vec_ovf [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};

    function automatic logic in_rdy(input bit w2);
        return w2 ? if2.in_ready : if8.in_ready;
    endfunction

    function automatic logic out_vld(input bit w2);
        return w2 ? if2.out_valid : if8.out_valid;
    endfunction

    function automatic logic [9:0] result(input bit w2);
        // {carry, sum(8), ovf}
        return w2 ? {if2.carry, 6'd0, if2.sum, if2.ovf} : {if8.carry, if8.sum, if8.ovf};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present operands after `gap` idle cycles and complete the input handshake.
    task automatic start_op(input bit w2, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input int gap);
        int n;
        repeat (gap) cycle();
        if (w2) begin
            if2.a = a[1:0]; if2.b = b[1:0]; if2.c = c; if2.in_valid = 1'b1;
        end else begin
            if8.a = a; if8.b = b; if8.c = c; if8.in_valid = 1'b1;
        end
        n = 0;
        while (!in_rdy(w2) && n < 50) begin
            cycle();
            n++;
        end
        if (!in_rdy(w2)) begin
            tests++; fails++;
            $display("FAIL accept_timeout w2=%0d in_ready=%0b required 1", w2, in_rdy(w2));
        end
        cycle();
        if2.in_valid = 1'b0;
        if8.in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen.
    task automatic wait_valid(input bit w2, output int lat);
        lat = 0;
        while (!out_vld(w2) && lat < 50) begin
            cycle();
            lat++;
        end
        if (!out_vld(w2)) begin
            tests++; fails++;
            $display("FAIL result_timeout w2=%0d out_valid=0 required 1", w2);
        end
    endtask

    task automatic take_result(input bit w2, input int gap);
        repeat (gap) cycle();
        if (w2) if2.out_ready = 1'b1; else if8.out_ready = 1'b1;
        cycle();
        if2.out_ready = 1'b0;
        if8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({if8.in_ready, if8.out_valid, if8.sum, if8.carry, if8.ovf, if8.busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset8 rdy=%0b vld=%0b sum=%h cy=%0b ovf=%0b busy=%0b required 1 0 00 0 0 0",
                     if8.in_ready, if8.out_valid, if8.sum, if8.carry, if8.ovf, if8.busy);
        end
        tests++;
        if ({if2.in_ready, if2.out_valid, if2.sum, if2.carry, if2.ovf, if2.busy} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset2 rdy=%0b vld=%0b sum=%h cy=%0b ovf=%0b busy=%0b required 1 0 0 0 0 0",
                     if2.in_ready, if2.out_valid, if2.sum, if2.carry, if2.ovf, if2.busy);
        end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_vectors();
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_op(1'b0, vec_a[i], vec_b[i], vec_c[i], 0);
            wait_valid(1'b0, lat);
            tests++;
            if (lat !== 4) begin
                fails++;
                $display("FAIL latency vec%0d got %0d required 4", i, lat);
            end
            tests++;
            if ({if8.carry, if8.sum, if8.ovf} !== {vec_cy[i], vec_sum[i], vec_ovf[i]}) begin
                fails++;
                $display("FAIL vector%0d cy/sum/ovf got %0b/%h/%0b required %0b/%h/%0b",
                         i, if8.carry, if8.sum, if8.ovf, vec_cy[i], vec_sum[i], vec_ovf[i]);
            end
            take_result(1'b0, 0);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        // 0x80 + 0xFF = 0x17F: sum 7F, carry 1, both negative -> positive: ovf 1
        start_op(1'b0, 8'h80, 8'hFF, 1'b0, 0);
        wait_valid(1'b0, lat);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if ({if8.out_valid, if8.in_ready, if8.busy, if8.carry, if8.sum, if8.ovf} !== {1'b1, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b1}) begin
                fails++;
                $display("FAIL backpressure cyc%0d vld=%0b rdy=%0b busy=%0b cy=%0b sum=%h ovf=%0b required 1 0 1 1 7f 1",
                         i, if8.out_valid, if8.in_ready, if8.busy, if8.carry, if8.sum, if8.ovf);
            end
            cycle();
        end
        take_result(1'b0, 0);
        tests++;
        if ({if8.out_valid, if8.in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL release vld=%0b rdy=%0b required 0 1", if8.out_valid, if8.in_ready);
        end
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        start_op(1'b0, 8'h22, 8'h11, 1'b0, 0);
        cycle();
        tests++;
        if ({if8.in_ready, if8.busy} !== 2'b01) begin
            fails++;
            $display("FAIL run_flags rdy=%0b busy=%0b required 0 1", if8.in_ready, if8.busy);
        end
        if8.a = 8'h11; if8.b = 8'h11; if8.c = 1'b1; if8.in_valid = 1'b1;
        cycle();
        if8.in_valid = 1'b0;
        wait_valid(1'b0, lat);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL ignore_latency got %0d required 2", lat);
        end
        tests++;
        if ({if8.carry, if8.sum, if8.ovf} !== {1'b0, 8'h33, 1'b0}) begin
            fails++;
            $display("FAIL ignore_result cy/sum/ovf got %0b/%h/%0b required 0/33/0", if8.carry, if8.sum, if8.ovf);
        end
        take_result(1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({if8.out_valid, if8.busy} !== 2'b00) begin
                fails++;
                $display("FAIL no_duplicate cyc%0d vld=%0b busy=%0b required 0 0", i, if8.out_valid, if8.busy);
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(1'b0, 8'hAA, 8'h55, 1'b1, 0);
        cycle();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({if8.in_ready, if8.out_valid, if8.sum, if8.carry, if8.ovf, if8.busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset rdy=%0b vld=%0b sum=%h cy=%0b ovf=%0b busy=%0b required 1 0 00 0 0 0",
                     if8.in_ready, if8.out_valid, if8.sum, if8.carry, if8.ovf, if8.busy);
        end
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({if8.out_valid, if8.busy} !== 2'b00) begin
                fails++;
                $display("FAIL post_reset cyc%0d vld=%0b busy=%0b required 0 0", i, if8.out_valid, if8.busy);
            end
            cycle();
        end
        start_op(1'b0, 8'h10, 8'h20, 1'b0, 0);
        wait_valid(1'b0, lat);
        tests++;
        if ({lat[3:0], if8.carry, if8.sum, if8.ovf} !== {4'd4, 1'b0, 8'h30, 1'b0}) begin
            fails++;
            $display("FAIL after_reset lat=%0d cy/sum/ovf got %0b/%h/%0b required 4 0/30/0",
                     lat, if8.carry, if8.sum, if8.ovf);
        end
        take_result(1'b0, 0);
    endtask

    task automatic test_random(input bit w2, input int nops);
        int         lat;
        int         w;
        logic [7:0] a, b, mask;
        logic       c;
        logic [8:0] full;
        logic [7:0] exp_sum;
        logic       exp_cy, exp_ovf, msb_a, msb_b, msb_s;
        logic [9:0] got, exp;
        w    = w2 ? 2 : 8;
        mask = w2 ? 8'h03 : 8'hFF;
        for (int i = 0; i < nops; i++) begin
            a = 8'($urandom) & mask;
            b = 8'($urandom) & mask;
            c = 1'($urandom);
            full    = {1'b0, a} + {1'b0, b} + {8'd0, c};
            exp_sum = full[7:0] & mask;
            exp_cy  = full[w];
            msb_a   = a[w-1];
            msb_b   = b[w-1];
            msb_s   = exp_sum[w-1];
            exp_ovf = (msb_a == msb_b) && (msb_s != msb_a);
            start_op(w2, a, b, c, $urandom_range(0, 2));
            wait_valid(w2, lat);
            got = result(w2);
            exp = {exp_cy, exp_sum, exp_ovf};
            tests++;
            if (got !== exp || lat !== w / 2) begin
                fails++;
                $display("FAIL random w=%0d op%0d a=%h b=%h c=%0b lat=%0d got cy/sum/ovf %0b/%h/%0b required lat=%0d %0b/%h/%0b",
                         w, i, a, b, c, lat, got[9], got[8:1], got[0], w / 2, exp_cy, exp_sum, exp_ovf);
            end
            take_result(w2, $urandom_range(0, 3));
            tests++;
            if (out_vld(w2) !== 1'b0) begin
                fails++;
                $display("FAIL random_dup w=%0d op%0d out_valid=%0b required 0", w, i, out_vld(w2));
            end
        end
    endtask

    initial begin
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = '0; if8.b = '0; if8.c = 1'b0;
        if2.in_valid = 1'b0; if2.out_ready = 1'b0; if2.a = '0; if2.b = '0; if2.c = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid();
        test_random(1'b0, 600);
        test_random(1'b1, 400);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
